// File: rtl/ps_pkg.sv
// Shared definitions for the program sequencer and its interrupt controller.
package ps_pkg;

    localparam int PS_PMA_SIZE = 16;
    localparam logic [15:0] PS_IVT_ADDR = 16'h0010;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TAKE = 2'd1,
        ST_ISR  = 2'd2
    } ps_int_state_t;

endpackage

// File: rtl/int_pc_stack.sv
// Return-PC LIFO: push writes the next free slot, pop loads the top entry into a
// registered read port. Requests against a full/empty stack are dropped.
module int_pc_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int PW = AW + 1
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [PW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_ptr == PW'(DEPTH));
    assign empty     = (r_ptr == '0);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && !full && !pop;

    // Storage has no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr     <= '0;
            r_rd_data <= '0;
        end else if (w_do_pop) begin
            r_rd_data <= r_mem[r_ptr[AW-1:0] - AW'(1)];
            r_ptr     <= r_ptr - PW'(1);
        end else if (w_do_push) begin
            r_ptr <= r_ptr + PW'(1);
        end
    end

    assign rd_data = r_rd_data;
    assign level   = r_ptr;

endmodule

// File: rtl/ps_interrupt_ctrl.sv
// External interrupt receiver: edge detect, pending latch, take/return FSM and
// a return-PC LIFO so ISRs can nest up to STACK_DEPTH levels.
module ps_interrupt_ctrl
    import ps_pkg::*;
#(
    parameter int                  PMA_SIZE    = PS_PMA_SIZE,
    parameter int                  STACK_DEPTH = 4,
    parameter logic [PMA_SIZE-1:0] IVT_ADDR    = PMA_SIZE'(PS_IVT_ADDR),
    parameter bit                  NEST_EN     = 1'b0
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                interrupt,
    input  logic                int_en,
    input  logic                ps_idle,
    input  logic                ps_instr_boundary,
    input  logic [PMA_SIZE-1:0] ps_pc,
    input  logic                ps_rti,
    output logic                int_redirect,
    output logic [PMA_SIZE-1:0] int_target,
    output logic                int_return_valid,
    output logic [PMA_SIZE-1:0] int_return_pc,
    output logic                int_pending,
    output logic                int_active,
    output logic                int_err
);

    localparam int PTR_W = $clog2(STACK_DEPTH) + 1;

    ps_int_state_t       r_state;
    ps_int_state_t       w_state_next;
    logic                r_int_q;
    logic                r_pending;
    logic                r_err;
    logic                r_ret_valid;
    logic [PMA_SIZE-1:0] r_target;

    logic                w_edge;
    logic                w_svc;
    logic                w_push;
    logic                w_pop;
    logic                w_err_set;
    logic                w_full;
    logic                w_empty;
    logic [PTR_W-1:0]    w_level;
    logic [PMA_SIZE-1:0] w_rd_data;

    assign w_edge = interrupt && !r_int_q;
    assign w_svc  = r_pending && int_en && (ps_idle || ps_instr_boundary) && !w_full
                    && ((r_state == ST_RUN) || NEST_EN);

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_err_set = ps_rti;
                if (w_svc) begin
                    w_push       = 1'b1;
                    w_state_next = ST_TAKE;
                end
            end
            ST_TAKE: begin
                w_err_set    = ps_rti;
                w_state_next = ST_ISR;
            end
            ST_ISR: begin
                // A return always beats a nested take in the same cycle.
                if (ps_rti) begin
                    if (w_empty) begin
                        w_err_set    = 1'b1;
                        w_state_next = ST_RUN;
                    end else begin
                        w_pop = 1'b1;
                        if (w_level == PTR_W'(1)) begin
                            w_state_next = ST_RUN;
                        end
                    end
                end else if (w_svc) begin
                    w_push       = 1'b1;
                    w_state_next = ST_TAKE;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_int_q     <= 1'b0;
            r_pending   <= 1'b0;
            r_err       <= 1'b0;
            r_ret_valid <= 1'b0;
            r_target    <= IVT_ADDR;
        end else begin
            r_state     <= w_state_next;
            r_int_q     <= interrupt;
            // A fresh edge in the take cycle keeps the request alive.
            r_pending   <= w_edge || (r_pending && !w_push);
            r_err       <= r_err || w_err_set;
            r_ret_valid <= w_pop;
            r_target    <= IVT_ADDR;
        end
    end

    int_pc_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PMA_SIZE)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data (ps_pc),
        .rd_data (w_rd_data),
        .level   (w_level),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign int_redirect     = (r_state == ST_TAKE);
    assign int_target       = r_target;
    assign int_return_valid = r_ret_valid;
    assign int_return_pc    = w_rd_data;
    assign int_pending      = r_pending;
    assign int_active       = !w_empty;
    assign int_err          = r_err;

endmodule

// File: tb/tb_ps_interrupt_ctrl.sv
// Directed bench: redirect/return events are predicted into a scoreboard queue
// with their expected cycle and matched as the DUT raises them.
module tb_ps_interrupt_ctrl;

    logic        clk;
    logic        reset;
    logic        interrupt;
    logic        int_en;
    logic        ps_idle;
    logic        ps_instr_boundary;
    logic [15:0] ps_pc;
    logic        ps_rti;

    logic        d0_redirect, d1_redirect;
    logic [15:0] d0_target, d1_target;
    logic        d0_ret_valid, d1_ret_valid;
    logic [15:0] d0_ret_pc, d1_ret_pc;
    logic        d0_pending, d1_pending;
    logic        d0_active, d1_active;
    logic        d0_err, d1_err;

    bit          sel;
    logic        m_redirect, m_ret_valid, m_pending, m_active, m_err;
    logic [15:0] m_target, m_ret_pc;

    typedef struct {
        bit          is_ret;
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    ps_interrupt_ctrl #(.NEST_EN(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .interrupt(interrupt), .int_en(int_en),
        .ps_idle(ps_idle), .ps_instr_boundary(ps_instr_boundary), .ps_pc(ps_pc),
        .ps_rti(ps_rti), .int_redirect(d0_redirect), .int_target(d0_target),
        .int_return_valid(d0_ret_valid), .int_return_pc(d0_ret_pc),
        .int_pending(d0_pending), .int_active(d0_active), .int_err(d0_err)
    );

    ps_interrupt_ctrl #(.NEST_EN(1'b1), .STACK_DEPTH(4)) u_dut1 (
        .clk(clk), .reset(reset), .interrupt(interrupt), .int_en(int_en),
        .ps_idle(ps_idle), .ps_instr_boundary(ps_instr_boundary), .ps_pc(ps_pc),
        .ps_rti(ps_rti), .int_redirect(d1_redirect), .int_target(d1_target),
        .int_return_valid(d1_ret_valid), .int_return_pc(d1_ret_pc),
        .int_pending(d1_pending), .int_active(d1_active), .int_err(d1_err)
    );

    assign m_redirect  = sel ? d1_redirect  : d0_redirect;
    assign m_target    = sel ? d1_target    : d0_target;
    assign m_ret_valid = sel ? d1_ret_valid : d0_ret_valid;
    assign m_ret_pc    = sel ? d1_ret_pc    : d0_ret_pc;
    assign m_pending   = sel ? d1_pending   : d0_pending;
    assign m_active    = sel ? d1_active    : d0_active;
    assign m_err       = sel ? d1_err       : d0_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input bit is_ret, input logic [15:0] val, input int dly);
        exp_t e;
        e.is_ret = is_ret;
        e.val    = val;
        e.cyc    = cyc + dly;
        sb_q.push_back(e);
    endtask

    // Observed and expected packed as {kind, value, cycle}.
    task automatic check_event(input bit is_ret, input logic [15:0] val);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk(is_ret ? "unexpected_return" : "unexpected_redirect",
                {15'b0, is_ret, val, 32'(cyc)}, 64'h0);
        end else begin
            e = sb_q.pop_front();
            chk(is_ret ? "return_event" : "redirect_event",
                {15'b0, is_ret, val, 32'(cyc)},
                {15'b0, e.is_ret, e.val, 32'(e.cyc)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (m_redirect)  check_event(1'b0, m_target);
        if (m_ret_valid) check_event(1'b1, m_ret_pc);
    endtask

    task automatic do_reset();
        interrupt = 0; int_en = 0; ps_idle = 0; ps_instr_boundary = 0;
        ps_pc = '0; ps_rti = 0;
        reset = 0;
        sb_q.delete();
        tick(); tick();
        chk("rst_redirect",  m_redirect,  0);
        chk("rst_ret_valid", m_ret_valid, 0);
        chk("rst_pending",   m_pending,   0);
        chk("rst_active",    m_active,    0);
        chk("rst_err",       m_err,       0);
        chk("rst_target",    m_target,    16'h0010);
        reset = 1;
        tick();
    endtask

    initial begin
        sel = 0;
        do_reset();

        // 1: single request from IDLE and its return
        ps_idle = 1; int_en = 1; ps_pc = 16'h0042; interrupt = 1;
        expect_ev(0, 16'h0010, 2);
        tick(); interrupt = 0; chk("t1_pending", m_pending, 1);
        tick(); chk("t1_active", m_active, 1);
        tick(); ps_rti = 1; expect_ev(1, 16'h0042, 1);
        tick(); ps_rti = 0; chk("t1_active_after_rti", m_active, 0);
        tick(); chk("t1_drain", sb_q.size(), 0);

        // 2: masked request held, taken once when enabled
        do_reset();
        ps_idle = 1; int_en = 0; ps_pc = 16'h0100; interrupt = 1;
        repeat (5) tick();
        interrupt = 0;
        tick(); chk("t2_pending_held", m_pending, 1);
        repeat (3) tick(); chk("t2_still_pending", m_pending, 1);
        int_en = 1; expect_ev(0, 16'h0010, 1);
        tick(); chk("t2_pending_cleared", m_pending, 0);
        tick(); ps_rti = 1; expect_ev(1, 16'h0100, 1);
        tick(); ps_rti = 0;
        repeat (3) tick(); chk("t2_drain", sb_q.size(), 0);

        // 3: no nesting; second request waits for the final RTI
        do_reset();
        ps_instr_boundary = 1; int_en = 1; ps_pc = 16'h0200; interrupt = 1;
        expect_ev(0, 16'h0010, 2);
        tick(); interrupt = 0; tick(); tick();
        ps_pc = 16'h0300; interrupt = 1;
        tick(); interrupt = 0; chk("t3_pending_in_isr", m_pending, 1);
        repeat (3) tick(); chk("t3_held", m_pending, 1);
        ps_rti = 1; expect_ev(1, 16'h0200, 1); expect_ev(0, 16'h0010, 2);
        tick(); ps_rti = 0;
        tick(); chk("t3_pending_taken", m_pending, 0);
        tick(); ps_rti = 1; expect_ev(1, 16'h0300, 1);
        tick(); ps_rti = 0;
        tick(); chk("t3_drain", sb_q.size(), 0);

        // 4: nesting to full depth, fifth request waits for the pops
        sel = 1;
        do_reset();
        ps_idle = 1; int_en = 1;
        for (int i = 1; i <= 5; i++) begin
            ps_pc = 16'(i); interrupt = 1;
            if (i <= 4) expect_ev(0, 16'h0010, 2);
            tick(); interrupt = 0; tick(); tick();
        end
        chk("t4_fifth_pending", m_pending, 1);
        chk("t4_active", m_active, 1);
        ps_rti = 1;
        expect_ev(1, 16'h0004, 1); expect_ev(1, 16'h0003, 2);
        expect_ev(1, 16'h0002, 3); expect_ev(1, 16'h0001, 4);
        expect_ev(0, 16'h0010, 5);
        repeat (4) tick();
        ps_rti = 0;
        chk("t4_pending_after_pops", m_pending, 1);
        chk("t4_empty_after_pops", m_active, 0);
        tick(); tick();
        ps_rti = 1; expect_ev(1, 16'h0005, 1);
        tick(); ps_rti = 0;
        tick(); chk("t4_drain", sb_q.size(), 0);

        // 5: RTI with empty LIFO, then reset in the middle of an ISR
        sel = 0;
        do_reset();
        ps_rti = 1;
        tick(); ps_rti = 0; chk("t5_err_set", m_err, 1);
        repeat (2) tick(); chk("t5_err_sticky", m_err, 1);
        ps_idle = 1; int_en = 1; ps_pc = 16'h0500; interrupt = 1;
        expect_ev(0, 16'h0010, 2);
        tick(); interrupt = 0; tick(); tick();
        chk("t5_active", m_active, 1);
        interrupt = 1;
        tick(); interrupt = 0; chk("t5_pending", m_pending, 1);
        reset = 0;
        #1;
        chk("t5_rst_redirect",  m_redirect,  0);
        chk("t5_rst_ret_valid", m_ret_valid, 0);
        chk("t5_rst_pending",   m_pending,   0);
        chk("t5_rst_active",    m_active,    0);
        chk("t5_rst_err",       m_err,       0);
        chk("t5_rst_ret_pc",    m_ret_pc,    0);
        tick(); reset = 1;
        repeat (3) tick();
        chk("t5_active_after_reset", m_active, 0);
        chk("t5_drain", sb_q.size(), 0);

        // 6: edge in the take cycle; RTI coincident with a nested service
        sel = 1;
        do_reset();
        ps_idle = 1; int_en = 0; ps_pc = 16'h0600; interrupt = 1;
        tick(); interrupt = 0;
        tick(); chk("t6_pending_masked", m_pending, 1);
        int_en = 1; interrupt = 1;
        expect_ev(0, 16'h0010, 1); expect_ev(0, 16'h0010, 3);
        tick(); interrupt = 0; ps_pc = 16'h0601;
        chk("t6_pending_kept", m_pending, 1);
        tick(); tick(); tick();
        interrupt = 1;
        tick(); interrupt = 0;
        ps_rti = 1; ps_pc = 16'h0602;
        expect_ev(1, 16'h0601, 1); expect_ev(0, 16'h0010, 2);
        tick(); ps_rti = 0;
        chk("t6_rti_first_pending", m_pending, 1);
        tick(); tick();
        ps_rti = 1;
        expect_ev(1, 16'h0602, 1); expect_ev(1, 16'h0600, 2);
        tick(); tick(); ps_rti = 0;
        tick();
        chk("t6_active_end", m_active, 0);
        chk("t6_drain", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
